reaction_stimulus: RTL and testbench

Stimulus side of the reaction-speed game. On `arm`, waits a pseudo-random delay counted in 1 ms ticks, then lights the LED and emits a one-cycle `start_pulse` for the reaction timer. A press during the wait is a false start. A press while lit ends the round with a one-cycle `stop_pulse`. The block sits between the debounced button and the timer and drives both timer triggers.

---
 rtl/reaction_pkg.sv | 24 ++
 rtl/reaction_stimulus_if.sv | 24 ++
 rtl/lfsr16.sv | 39 +++
 rtl/reaction_stimulus.sv | 146 ++++++++++++++
 tb/tb_reaction_stimulus.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction-game stimulus block.
// Holds the state encoding, default timing constants and the LFSR tap mask.
package reaction_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_LIT  = 2'd2
   } state_t;

   localparam int unsigned DEF_MIN_DELAY_MS = 1000;
   localparam int unsigned DEF_RAND_BITS    = 11;
   localparam int unsigned DEF_TIMEOUT_MS   = 5000;
   localparam logic [15:0] DEF_SEED         = 16'hACE1;

   // Taps 16,14,13,11 of a right-shifting Fibonacci register map to bits 0,2,3,5.
   localparam logic [15:0] LFSR_TAPS = 16'h002D;

   // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
   function automatic logic [15:0] seed_fix(input logic [15:0] seed);
      return (seed == 16'd0) ? 16'd1 : seed;
   endfunction

endpackage

// File: rtl/reaction_stimulus_if.sv
// Handshake bundle between the button/tick sources, the stimulus block and the timer.
// The master side drives tick, arm and press; the slave side returns the round status.
interface reaction_stimulus_if;
   logic        tick_1ms;
   logic        arm;
   logic        press;
   logic        led;
   logic        start_pulse;
   logic        stop_pulse;
   logic        foul;
   logic        timeout;
   logic        busy;
   logic [15:0] delay_ms;

   modport master (
      output tick_1ms, arm, press,
      input  led, start_pulse, stop_pulse, foul, timeout, busy, delay_ms
   );

   modport slave (
      input  tick_1ms, arm, press,
      output led, start_pulse, stop_pulse, foul, timeout, busy, delay_ms
   );
endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), shifting right each clock.
// Asynchronous active-high reset loads the seed.
module lfsr16
   import reaction_pkg::*;
#(
   parameter logic [15:0] SEED = DEF_SEED
) (
   input  logic        clk,
   input  logic        reset,
   output logic [15:0] lfsr
);

   localparam logic [15:0] SEED_EFF = seed_fix(SEED);

   logic [15:0] lfsr_reg;
   logic [15:0] lfsr_next;
   logic        feedback;

   assign feedback      = ^(lfsr_reg & LFSR_TAPS);
   assign lfsr_next[15] = feedback;

   genvar gi;
   generate
      for (gi = 0; gi < 15; gi++) begin : g_shift
         assign lfsr_next[gi] = lfsr_reg[gi+1];
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lfsr_reg <= SEED_EFF;
      end else begin
         lfsr_reg <= lfsr_next;
      end
   end

   assign lfsr = lfsr_reg;

endmodule

// File: rtl/reaction_stimulus.sv
// Reaction-game stimulus: random 1 ms-tick wait after arm, then LED plus timer start/stop pulses.
// Optional LIT timeout is built only when REACTION_TIMEOUT_EN is defined.
module reaction_stimulus
   import reaction_pkg::*;
#(
   parameter int unsigned MIN_DELAY_MS = DEF_MIN_DELAY_MS,
   parameter int unsigned RAND_BITS    = DEF_RAND_BITS,
   parameter int unsigned TIMEOUT_MS   = DEF_TIMEOUT_MS,
   parameter logic [15:0] SEED         = DEF_SEED
) (
   input  logic               clk,
   input  logic               reset,
   reaction_stimulus_if.slave bus
);

   localparam logic [15:0] RAND_MASK = 16'((32'd1 << RAND_BITS) - 32'd1);

   generate
      if ((RAND_BITS > 16) ||
          (MIN_DELAY_MS + (32'd1 << RAND_BITS) - 32'd1 > 32'd65535) ||
          (TIMEOUT_MS == 0) || (TIMEOUT_MS > 65535)) begin : g_param_check
         $error("reaction_stimulus: illegal parameter combination");
      end
   endgenerate

   logic [15:0] lfsr_value;
   logic [15:0] delay_next;

   state_t      state_reg;
   logic [15:0] count_reg;
   logic [15:0] delay_reg;
   logic        led_reg;
   logic        start_reg;
   logic        stop_reg;
   logic        foul_reg;
   logic        busy_reg;
`ifdef REACTION_TIMEOUT_EN
   logic [15:0] lit_cnt_reg;
   logic        timeout_reg;
`endif

   lfsr16 #(
      .SEED (SEED)
   ) u_lfsr (
      .clk   (clk),
      .reset (reset),
      .lfsr  (lfsr_value)
   );

   assign delay_next = 16'(MIN_DELAY_MS) + (lfsr_value & RAND_MASK);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg   <= ST_IDLE;
         count_reg   <= 16'd0;
         delay_reg   <= 16'd0;
         led_reg     <= 1'b0;
         start_reg   <= 1'b0;
         stop_reg    <= 1'b0;
         foul_reg    <= 1'b0;
         busy_reg    <= 1'b0;
`ifdef REACTION_TIMEOUT_EN
         lit_cnt_reg <= 16'd0;
         timeout_reg <= 1'b0;
`endif
      end else begin
         start_reg <= 1'b0;
         stop_reg  <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (bus.arm) begin
                  delay_reg   <= delay_next;
                  count_reg   <= delay_next;
                  foul_reg    <= 1'b0;
                  busy_reg    <= 1'b1;
                  state_reg   <= ST_WAIT;
`ifdef REACTION_TIMEOUT_EN
                  timeout_reg <= 1'b0;
`endif
               end
            end

            // A press beats a coincident expiring tick, so it is checked first.
            ST_WAIT: begin
               if (bus.press) begin
                  foul_reg  <= 1'b1;
                  busy_reg  <= 1'b0;
                  state_reg <= ST_IDLE;
               end else if (bus.tick_1ms) begin
                  if (count_reg <= 16'd1) begin
                     count_reg   <= 16'd0;
                     led_reg     <= 1'b1;
                     start_reg   <= 1'b1;
                     state_reg   <= ST_LIT;
`ifdef REACTION_TIMEOUT_EN
                     lit_cnt_reg <= 16'd0;
`endif
                  end else begin
                     count_reg <= count_reg - 16'd1;
                  end
               end
            end

            ST_LIT: begin
               if (bus.press) begin
                  led_reg   <= 1'b0;
                  stop_reg  <= 1'b1;
                  busy_reg  <= 1'b0;
                  state_reg <= ST_IDLE;
`ifdef REACTION_TIMEOUT_EN
               end else if (bus.tick_1ms) begin
                  if (lit_cnt_reg == 16'(TIMEOUT_MS - 1)) begin
                     led_reg     <= 1'b0;
                     stop_reg    <= 1'b1;
                     busy_reg    <= 1'b0;
                     timeout_reg <= 1'b1;
                     state_reg   <= ST_IDLE;
                  end else begin
                     lit_cnt_reg <= lit_cnt_reg + 16'd1;
                  end
`endif
               end
            end

            default: begin
               state_reg <= ST_IDLE;
               led_reg   <= 1'b0;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.led         = led_reg;
   assign bus.start_pulse = start_reg;
   assign bus.stop_pulse  = stop_reg;
   assign bus.foul        = foul_reg;
   assign bus.busy        = busy_reg;
   assign bus.delay_ms    = delay_reg;
`ifdef REACTION_TIMEOUT_EN
   assign bus.timeout     = timeout_reg;
`else
   assign bus.timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_reaction_stimulus.sv
// Self-checking bench for reaction_stimulus: directed scenarios plus randomized rounds
// checked cycle by cycle against a round-level model of the game rules.
module tb_reaction_stimulus;

   localparam int          MIN_D  = 4;
   localparam int          RB     = 3;
   localparam int          TMO    = 10;
   localparam logic [15:0] SEED_V = 16'hACE1;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   reaction_stimulus_if bus ();

   reaction_stimulus #(
      .MIN_DELAY_MS (MIN_D),
      .RAND_BITS    (RB),
      .TIMEOUT_MS   (TMO),
      .SEED         (SEED_V)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int          checks   = 0;
   int          failures = 0;
   logic [15:0] m_lfsr   = SEED_V;
   logic [15:0] lfsr_pre = SEED_V;
   logic [15:0] m_delay  = 16'd0;
   logic        m_foul   = 1'b0;
   logic        m_timeout = 1'b0;
   logic        rst_req  = 1'b1;
   int          tick_phase = 0;
   logic        last_tick = 1'b0;
   logic        timer_run = 1'b0;
   logic [15:0] timer_cnt = 16'd0;

   // Reference sequence: right-shifting Fibonacci LFSR, taps 16,14,13,11.
   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
   endfunction

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs at the falling edge, sample just after the rising edge.
   task automatic cyc(input logic a, input logic p);
      @(negedge clk);
      reset        = rst_req;
      bus.arm      = a;
      bus.press    = p;
      last_tick    = (tick_phase == 3);
      bus.tick_1ms = last_tick;
      tick_phase   = (tick_phase + 1) % 4;
      lfsr_pre     = m_lfsr;
      @(posedge clk);
      #1;
      if (reset) m_lfsr = SEED_V;
      else       m_lfsr = lfsr_step(m_lfsr);
      if (timer_run && last_tick) timer_cnt = timer_cnt + 16'd1;
      if (bus.start_pulse === 1'b1) begin
         timer_run = 1'b1;
         timer_cnt = 16'd0;
      end
      if (bus.stop_pulse === 1'b1) timer_run = 1'b0;
      chk1("pulse_overlap", bus.start_pulse & bus.stop_pulse, 1'b0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk1({tag, "_led"}, bus.led, 1'b0);
      chk1({tag, "_start"}, bus.start_pulse, 1'b0);
      chk1({tag, "_stop"}, bus.stop_pulse, 1'b0);
      chk1({tag, "_foul"}, bus.foul, 1'b0);
      chk1({tag, "_timeout"}, bus.timeout, 1'b0);
      chk1({tag, "_busy"}, bus.busy, 1'b0);
      chk16({tag, "_delay"}, bus.delay_ms, 16'd0);
   endtask

   task automatic wait_lfsr(input logic [2:0] v);
      for (int i = 0; i < 200; i++) begin
         if (m_lfsr[2:0] == v) return;
         cyc(1'b0, 1'b0);
      end
      chk1("wait_lfsr_bound", 1'b1, 1'b0);
   endtask

   // mode 0: press during WAIT on tick k (k=0: the expiring tick)
   // mode 1: press one cycle after the k-th LIT tick
   // mode 2: no press while lit
   // mode 3: asynchronous reset after k LIT ticks
   task automatic run_round(input int mode_in, input int k_in, input bit extra_arm, input int gap);
      int   mode;
      int   k;
      int   seen;
      int   lit;
      int   budget;
      logic t;
      logic p;
      logic a;
      mode = mode_in;
      k    = k_in;

      for (int i = 0; i < gap; i++) begin
         cyc(1'b0, 1'($urandom_range(0, 1)));
         chk1("idle_busy", bus.busy, 1'b0);
         chk1("idle_led", bus.led, 1'b0);
         chk1("idle_foul", bus.foul, m_foul);
         chk1("idle_timeout", bus.timeout, m_timeout);
      end

      cyc(1'b1, 1'b0);
      m_delay   = 16'(MIN_D) + {13'd0, lfsr_pre[2:0]};
      m_foul    = 1'b0;
      m_timeout = 1'b0;
      $display("round mode=%0d k=%0d lfsr=%04h delay=%0d", mode, k, lfsr_pre, m_delay);
      chk16("arm_delay", bus.delay_ms, m_delay);
      chk1("arm_busy", bus.busy, 1'b1);
      chk1("arm_foul_clr", bus.foul, 1'b0);
      chk1("arm_timeout_clr", bus.timeout, 1'b0);
      chk1("arm_led", bus.led, 1'b0);

      if (mode == 0 && (k == 0 || k > int'(m_delay))) k = int'(m_delay);

      seen   = 0;
      budget = 0;
      forever begin
         t = (tick_phase == 3);
         p = (mode == 0) && t && (seen + 1 == k);
         a = extra_arm && ($urandom_range(0, 3) == 0);
         cyc(a, p);
         if (p) begin
            chk1("foul_set", bus.foul, 1'b1);
            chk1("foul_busy", bus.busy, 1'b0);
            chk1("foul_led", bus.led, 1'b0);
            chk1("foul_start", bus.start_pulse, 1'b0);
            chk1("foul_stop", bus.stop_pulse, 1'b0);
            m_foul = 1'b1;
            return;
         end
         if (t) seen++;
         chk16("wait_delay_held", bus.delay_ms, m_delay);
         chk1("wait_busy", bus.busy, 1'b1);
         if (t && seen == int'(m_delay)) begin
            chk1("start_pulse", bus.start_pulse, 1'b1);
            chk1("start_led", bus.led, 1'b1);
            break;
         end
         chk1("wait_no_start", bus.start_pulse, 1'b0);
         chk1("wait_led_off", bus.led, 1'b0);
         budget++;
         if (budget > 300) begin
            chk1("wait_bound", 1'b1, 1'b0);
            return;
         end
      end

      lit    = 0;
      budget = 0;
      forever begin
         t = (tick_phase == 3);
         if (mode == 3 && lit == k && !t) begin
            #2;
            reset     = 1'b1;
            rst_req   = 1'b1;
            m_lfsr    = SEED_V;
            m_foul    = 1'b0;
            m_timeout = 1'b0;
            timer_run = 1'b0;
            #1;
            chk_all_zero("lit_reset");
            cyc(1'b0, 1'b0);
            cyc(1'b0, 1'b0);
            chk_all_zero("lit_reset_held");
            rst_req = 1'b0;
            return;
         end
         p = (mode == 1) && (lit == k) && !t;
         cyc(1'b0, p);
         if (t) lit++;
         if (p) begin
            chk1("stop_pulse", bus.stop_pulse, 1'b1);
            chk1("stop_led", bus.led, 1'b0);
            chk1("stop_busy", bus.busy, 1'b0);
            chk1("stop_foul", bus.foul, 1'b0);
            chk1("stop_timeout", bus.timeout, 1'b0);
            chk16("reaction_time", timer_cnt, 16'(k));
            return;
         end
`ifdef REACTION_TIMEOUT_EN
         if (mode == 2 && t && lit == TMO) begin
            chk1("timeout_stop", bus.stop_pulse, 1'b1);
            chk1("timeout_flag", bus.timeout, 1'b1);
            chk1("timeout_led", bus.led, 1'b0);
            chk1("timeout_busy", bus.busy, 1'b0);
            m_timeout = 1'b1;
            return;
         end
`else
         if (mode == 2 && t && lit == 20) begin
            mode = 1;
            k    = lit;
         end
`endif
         chk1("lit_led", bus.led, 1'b1);
         chk1("lit_no_start", bus.start_pulse, 1'b0);
         chk1("lit_no_stop", bus.stop_pulse, 1'b0);
         chk1("lit_busy", bus.busy, 1'b1);
         chk1("lit_timeout", bus.timeout, 1'b0);
         budget++;
         if (budget > 300) begin
            chk1("lit_bound", 1'b1, 1'b0);
            return;
         end
      end
   endtask

   initial begin
      bus.arm      = 1'b0;
      bus.press    = 1'b0;
      bus.tick_1ms = 1'b0;

      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);
      chk_all_zero("in_reset");
      rst_req = 1'b0;
      cyc(1'b0, 1'b0);
      chk_all_zero("after_reset");

      // Scenarios 1 and 2: arm when lfsr[2:0]=5, react 3 ticks after start.
      wait_lfsr(3'd5);
      run_round(1, 3, 1'b0, 0);
      chk16("s1_delay_9", bus.delay_ms, 16'd9);

      // Scenario 3: foul at tick 2, then next arm clears it.
      run_round(0, 2, 1'b0, 3);
      run_round(1, 1, 1'b0, 2);

      // Scenario 4: press coincides with the expiring tick.
      run_round(0, 0, 1'b0, 1);

      // Scenario 5: no press while lit.
      run_round(2, 0, 1'b0, 2);

      // Scenario 6: extra arms during WAIT, reset while lit.
      run_round(3, 2, 1'b1, 1);

      for (int r = 0; r < 14; r++) begin
         run_round(int'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 9)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
